fsm5_initiator: RTL and testbench

Synthesizable initiator for the FSM5 pattern-search handshake (start/AVAIL/data_in/DONE/flag). It accepts a test command, waits for the searcher to report available, pulses `start`, and streams 100 four-bit data beats. The stream either contains the pattern `4'b1011` at a chosen beat or excludes it entirely. The block then checks the searcher's DONE/flag response against the required timing and reports one result per command. It sits between a command source (sequencer or CPU register block) and an FSM5 instance, and it is the drive side of the same protocol FSM5 receives.

---
 rtl/fsm5_initiator.sv | 160 ++++++++++++++++
 tb/tb_fsm5_initiator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm5_initiator.sv
// FSM5 drive-side initiator: takes a hit/miss command, streams one search window
// to the searcher, then grades the searcher's DONE/flag response.
module fsm5_initiator #(
  parameter int          WINDOW    = 100,
  parameter logic [3:0]  PATTERN   = 4'b1011,
  parameter int          TIMEOUT   = 127,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_hit,
  input  logic [6:0] cmd_pos,
  output logic       start,
  output logic [3:0] data,
  input  logic       avail,
  input  logic       done,
  input  logic [1:0] flag,
  output logic       res_valid,
  output logic [1:0] res_flag,
  output logic [7:0] res_latency,
  output logic       res_err
);

  localparam logic [7:0] WIN8 = 8'(WINDOW);
  localparam logic [7:0] TO8  = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WAIT_AVAIL, START, RUN, DONE2, CHECK, REPORT
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [6:0] pos;
  } cmd_t;

  state_t      state;
  cmd_t        cmd_q;
  logic [7:0]  cyc;
  logic [15:0] lfsr;
  logic        err_q;
  logic [1:0]  flag_q;
  logic [7:0]  lat_q;

  logic [6:0]  pos_clamp;
  logic [7:0]  exp_lat;
  logic [1:0]  exp_flag;
  logic [15:0] lfsr_nxt;
  logic        err_now;

  assign cmd_ready = (state == IDLE) & ~reset;

  always_comb begin
    if (cmd_pos == 7'd0)              pos_clamp = 7'd1;
    else if (cmd_pos > 7'(WINDOW))    pos_clamp = 7'(WINDOW);
    else                              pos_clamp = cmd_pos;
  end

  // Fibonacci taps 16,14,13,11
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign exp_lat  = cmd_q.hit ? ({1'b0, cmd_q.pos} + 8'd2) : (WIN8 + 8'd2);
  assign exp_flag = cmd_q.hit ? 2'b01 : 2'b00;

  // Filler never carries PATTERN, so a hit run has exactly one match.
  function automatic logic [3:0] beat(input logic hit, input logic [6:0] pos,
                                      input logic [7:0] k, input logic [3:0] rnd);
    if (hit && k == {1'b0, pos})  beat = PATTERN;
    else if (hit && k > {1'b0, pos}) beat = 4'd0;
    else if (rnd == PATTERN)      beat = 4'd0;
    else                          beat = rnd;
  endfunction

  always_comb begin
    err_now = 1'b0;
    case (state)
      START: err_now = done & avail;
      RUN: begin
        if (done) err_now = avail | (cyc != exp_lat) | (flag != exp_flag);
        else      err_now = avail | (cyc == TO8);
      end
      DONE2:   err_now = ~done | (flag != flag_q) | (done & avail);
      CHECK:   err_now = done | ~avail;
      default: err_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_q       <= '0;
      cyc         <= '0;
      lfsr        <= LFSR_SEED;
      err_q       <= 1'b0;
      flag_q      <= '0;
      lat_q       <= '0;
      start       <= 1'b0;
      data        <= '0;
      res_valid   <= 1'b0;
      res_flag    <= '0;
      res_latency <= '0;
      res_err     <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err_q     <= err_q | err_now;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q <= '{hit: cmd_hit, pos: pos_clamp};
            err_q <= 1'b0;
            state <= WAIT_AVAIL;
          end
        end
        WAIT_AVAIL: begin
          if (avail) begin
            start <= 1'b1;
            cyc   <= '0;
            state <= START;
          end
        end
        START: begin
          start <= 1'b0;
          data  <= beat(cmd_q.hit, cmd_q.pos, 8'd1, lfsr[3:0]);
          cyc   <= 8'd1;
          state <= RUN;
        end
        RUN: begin
          lfsr <= lfsr_nxt;
          if (done) begin
            flag_q <= flag;
            lat_q  <= cyc;
            data   <= '0;
            state  <= DONE2;
          end else if (cyc == TO8) begin
            data        <= '0;
            res_valid   <= 1'b1;
            res_flag    <= 2'b00;
            res_latency <= TO8;
            res_err     <= 1'b1;
            state       <= REPORT;
          end else begin
            data <= (cyc < WIN8) ? beat(cmd_q.hit, cmd_q.pos, cyc + 8'd1, lfsr_nxt[3:0]) : 4'd0;
            cyc  <= cyc + 8'd1;
          end
        end
        DONE2: state <= CHECK;
        CHECK: begin
          res_valid   <= 1'b1;
          res_flag    <= flag_q;
          res_latency <= lat_q;
          res_err     <= err_q | err_now;
          state       <= REPORT;
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm5_initiator.sv
// Bench for fsm5_initiator: behavioural FSM5 responder plus spec-level expectations.
module tb_fsm5_initiator;

  localparam int         WINDOW  = 100;
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         TIMEOUT = 127;
  localparam int M_NOM = 0, M_SHORT = 1, M_BADFLAG = 2, M_NEVER = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_hit;
  logic [6:0] cmd_pos;
  logic       start;
  logic [3:0] data;
  logic       avail, done;
  logic [1:0] flag;
  logic       res_valid;
  logic [1:0] res_flag;
  logic [7:0] res_latency;
  logic       res_err;

  int n_checks = 0;
  int n_pass   = 0;

  fsm5_initiator dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_hit(cmd_hit), .cmd_pos(cmd_pos), .start(start), .data(data),
    .avail(avail), .done(done), .flag(flag), .res_valid(res_valid),
    .res_flag(res_flag), .res_latency(res_latency), .res_err(res_err)
  );

  always #5 clk = ~clk;

  function automatic int clamp_pos(input int p);
    if (p == 0) return 1;
    if (p > WINDOW) return WINDOW;
    return p;
  endfunction

  // Issues one command and plays the searcher; mode selects responder faults.
  task automatic run_cmd(input bit hit, input int pos, input int mode, input int avail_hold,
      input bit pulse_busy, output bit got_res, output int res_cyc, output logic [1:0] rflag,
      output logic [7:0] rlat, output logic rerr, output int beat_bad, output int start_t,
      output int start_cnt, output logic ready_after, output int idle_starts);
    int n, k_seen, d, kp;
    bit started;
    kp = clamp_pos(pos);
    got_res = 0; res_cyc = -1; rflag = '0; rlat = '0; rerr = 1'b0; beat_bad = 0;
    start_t = -1; start_cnt = 0; ready_after = 1'b0; idle_starts = 0;
    started = 0; n = -1; k_seen = -1;
    cmd_hit = hit; cmd_pos = 7'(pos); cmd_valid = 1'b1; done = 1'b0; flag = 2'b00;
    avail = (avail_hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int t = 0; t < 400 && !got_res; t++) begin
      @(posedge clk); #1;
      if (start === 1'b1) start_cnt++;
      if (!started && start === 1'b1) begin started = 1; n = 0; start_t = t; end
      else if (started) n++;
      if (!started) begin
        if (data !== 4'b0) beat_bad++;
        avail = (t + 1 >= avail_hold);
        continue;
      end
      if (n >= 1 && n <= WINDOW) begin
        if (hit && n == kp) begin if (data !== PATTERN) beat_bad++; end
        else if (hit && n > kp) begin if (data !== 4'b0) beat_bad++; end
        else if (data === PATTERN || $isunknown(data)) beat_bad++;
      end else if (data !== 4'b0) beat_bad++;
      if (res_valid === 1'b1) begin
        got_res = 1; res_cyc = n; rflag = res_flag; rlat = res_latency; rerr = res_err;
      end
      if (n >= 1 && n <= WINDOW && data === PATTERN && k_seen < 0) k_seen = n;
      d = (k_seen > 0) ? k_seen + 2 : WINDOW + 2;
      done  = (mode != M_NEVER) && (n == d || (n == d + 1 && mode != M_SHORT));
      flag  = (k_seen > 0 && mode != M_BADFLAG) ? 2'b01 : 2'b00;
      avail = (mode != M_NEVER) && (n >= d + 2);
      if (pulse_busy) cmd_valid = (n == 10);
    end
    done = 1'b0; flag = 2'b00; cmd_valid = 1'b0;
    @(posedge clk); #1;
    ready_after = cmd_ready;
    if (pulse_busy)
      for (int t = 0; t < 20; t++) begin
        @(posedge clk); #1;
        if (start === 1'b1) idle_starts++;
      end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_hit = 1'b0; cmd_pos = '0;
    avail = 1'b0; done = 1'b0; flag = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({start, data, res_valid, res_flag, res_latency, res_err, cmd_ready} !== 17'd0)
      $display("FAIL reset_outputs got start=%b data=%h rv=%b rf=%b rl=%0d re=%b rdy=%b want all 0",
               start, data, res_valid, res_flag, res_latency, res_err, cmd_ready);
    else n_pass++;
    reset = 1'b0; #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", cmd_ready); else n_pass++;
  endtask

  task automatic test_hit_edges();
    int pos_list[3] = '{1, 100, 0};
    bit g; int rc, bb, st, sc, is; logic [1:0] rf; logic [7:0] rl; logic re, ra;
    int el;
    foreach (pos_list[i]) begin
      run_cmd(1'b1, pos_list[i], M_NOM, 0, 1'b0, g, rc, rf, rl, re, bb, st, sc, ra, is);
      el = clamp_pos(pos_list[i]) + 2;
      n_checks++; if (!g) $display("FAIL hit%0d_res got=none want=res_valid", pos_list[i]); else n_pass++;
      n_checks++; if (rl !== 8'(el)) $display("FAIL hit%0d_lat got=%0d want=%0d", pos_list[i], rl, el); else n_pass++;
      n_checks++; if (rf !== 2'b01) $display("FAIL hit%0d_flag got=%b want=01", pos_list[i], rf); else n_pass++;
      n_checks++; if (re !== 1'b0) $display("FAIL hit%0d_err got=%b want=0", pos_list[i], re); else n_pass++;
      n_checks++; if (rc != el + 3) $display("FAIL hit%0d_rescyc got=%0d want=%0d", pos_list[i], rc, el + 3); else n_pass++;
      n_checks++; if (bb != 0) $display("FAIL hit%0d_beats got=%0d bad want=0", pos_list[i], bb); else n_pass++;
      n_checks++; if (st != 0 || sc != 1) $display("FAIL hit%0d_start got t=%0d cnt=%0d want t=0 cnt=1", pos_list[i], st, sc); else n_pass++;
      n_checks++; if (ra !== 1'b1) $display("FAIL hit%0d_ready got=%b want=1", pos_list[i], ra); else n_pass++;
    end
  endtask

  task automatic test_miss();
    bit g; int rc, bb, st, sc, is; logic [1:0] rf; logic [7:0] rl; logic re, ra;
    run_cmd(1'b0, 37, M_NOM, 0, 1'b0, g, rc, rf, rl, re, bb, st, sc, ra, is);
    n_checks++; if (!g || rl !== 8'd102) $display("FAIL miss_lat got=%0d want=102", rl); else n_pass++;
    n_checks++; if (rf !== 2'b00 || re !== 1'b0) $display("FAIL miss_flag_err got=%b/%b want=00/0", rf, re); else n_pass++;
    n_checks++; if (rc != 105) $display("FAIL miss_rescyc got=%0d want=105", rc); else n_pass++;
    n_checks++; if (bb != 0) $display("FAIL miss_beats got=%0d bad want=0", bb); else n_pass++;
  endtask

  task automatic test_faults();
    bit g; int rc, bb, st, sc, is; logic [1:0] rf; logic [7:0] rl; logic re, ra;
    run_cmd(1'b1, 7, M_SHORT, 0, 1'b0, g, rc, rf, rl, re, bb, st, sc, ra, is);
    n_checks++; if (!g || re !== 1'b1) $display("FAIL short_done_err got=%b want=1", re); else n_pass++;
    n_checks++; if (rl !== 8'd9 || rc != 12) $display("FAIL short_done_lat got=%0d@%0d want=9@12", rl, rc); else n_pass++;
    run_cmd(1'b1, 20, M_BADFLAG, 0, 1'b0, g, rc, rf, rl, re, bb, st, sc, ra, is);
    n_checks++; if (!g || re !== 1'b1) $display("FAIL badflag_err got=%b want=1", re); else n_pass++;
    n_checks++; if (rf !== 2'b00) $display("FAIL badflag_flag got=%b want=00", rf); else n_pass++;
    n_checks++; if (rl !== 8'd22) $display("FAIL badflag_lat got=%0d want=22", rl); else n_pass++;
  endtask

  task automatic test_timeout_avail();
    bit g; int rc, bb, st, sc, is; logic [1:0] rf; logic [7:0] rl; logic re, ra;
    run_cmd(1'b1, 30, M_NEVER, 10, 1'b0, g, rc, rf, rl, re, bb, st, sc, ra, is);
    n_checks++; if (st != 10 || sc != 1) $display("FAIL avail_wait got start_t=%0d cnt=%0d want 10/1", st, sc); else n_pass++;
    n_checks++; if (!g || rc != 128) $display("FAIL timeout_rescyc got=%0d want=128", rc); else n_pass++;
    n_checks++; if (rl !== 8'(TIMEOUT) || rf !== 2'b00 || re !== 1'b1)
      $display("FAIL timeout_res got lat=%0d flag=%b err=%b want 127/00/1", rl, rf, re); else n_pass++;
    n_checks++; if (ra !== 1'b1) $display("FAIL timeout_ready got=%b want=1", ra); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    bit seen; int extra;
    bit g; int rc, bb, st, sc, is; logic [1:0] rf; logic [7:0] rl; logic re, ra;
    avail = 1'b1; done = 1'b0; flag = 2'b00;
    cmd_hit = 1'b1; cmd_pos = 7'd60; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(posedge clk); #1;
      if (start === 1'b1) seen = 1;
    end
    avail = 1'b0;
    n_checks++; if (!seen) $display("FAIL midrst_start got=none want=start"); else n_pass++;
    repeat (50) @(posedge clk);
    #1; reset = 1'b1; #1;
    n_checks++; if (start !== 1'b0 || data !== 4'b0 || res_valid !== 1'b0 || res_latency !== 8'd0)
      $display("FAIL midrst_clear got start=%b data=%h rv=%b rl=%0d want 0", start, data, res_valid, res_latency);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; avail = 1'b1; #1;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL midrst_ready got=%b want=1", cmd_ready); else n_pass++;
    extra = 0;
    for (int t = 0; t < 150; t++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1 || start === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL midrst_quiet got=%0d events want=0", extra); else n_pass++;
    run_cmd(1'b1, 15, M_NOM, 0, 1'b0, g, rc, rf, rl, re, bb, st, sc, ra, is);
    n_checks++; if (!g || rl !== 8'd17 || rf !== 2'b01 || re !== 1'b0)
      $display("FAIL midrst_after got lat=%0d flag=%b err=%b want 17/01/0", rl, rf, re); else n_pass++;
  endtask

  task automatic test_random();
    bit g, hit; int pos, el, rc, bb, st, sc, is; logic [1:0] rf; logic [7:0] rl; logic re, ra;
    for (int i = 0; i < 6; i++) begin
      hit = 1'($urandom_range(0, 1));
      pos = int'($urandom_range(0, 127));
      el  = hit ? clamp_pos(pos) + 2 : WINDOW + 2;
      run_cmd(hit, pos, M_NOM, 0, (i == 2), g, rc, rf, rl, re, bb, st, sc, ra, is);
      n_checks++;
      if (!g || rl !== 8'(el) || rf !== (hit ? 2'b01 : 2'b00) || re !== 1'b0 || rc != el + 3)
        $display("FAIL rand%0d hit=%0d pos=%0d got lat=%0d flag=%b err=%b cyc=%0d want lat=%0d err=0 cyc=%0d",
                 i, hit, pos, rl, rf, re, rc, el, el + 3);
      else n_pass++;
      n_checks++; if (bb != 0) $display("FAIL rand%0d_beats got=%0d bad want=0", i, bb); else n_pass++;
      if (i == 2) begin
        n_checks++; if (is != 0) $display("FAIL busy_cmd_queued got=%0d starts want=0", is); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit_edges();
    test_miss();
    test_faults();
    test_timeout_avail();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
